// File: rtl/stream_pkg.sv
// Shared stream width-conversion types and lane-mask helpers used by the
// upsizer/downsizer pair.
package stream_pkg;

   localparam int T_DATA_WIDTH_DEF = 4;
   localparam int T_DATA_RATIO_DEF = 2;
   localparam int MAX_RATIO        = 32;

   typedef logic [T_DATA_WIDTH_DEF-1:0] lane_t;
   typedef logic [T_DATA_RATIO_DEF-1:0] keep_t;
   typedef logic [MAX_RATIO-1:0]        mask_ext_t;

   // Returns 0 for an empty mask; callers gate on a non-zero mask.
   function automatic int unsigned lowest_set_idx(input mask_ext_t mask);
      int unsigned idx;
      idx = 0;
      for (int i = MAX_RATIO - 1; i >= 0; i--) begin
         if (mask[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

   function automatic logic is_onehot(input mask_ext_t mask);
      return (mask != '0) && ((mask & (mask - mask_ext_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/stream_lane_sel.sv
// Picks the next lane to emit from a wide word: the lowest lane still pending
// in the remaining-mask, plus whether it is the only lane left.
module stream_lane_sel
   import stream_pkg::*;
#(
   parameter  int T_DATA_WIDTH = T_DATA_WIDTH_DEF,
   parameter  int T_DATA_RATIO = T_DATA_RATIO_DEF,
   localparam int IDX_W        = $clog2(T_DATA_RATIO)
) (
   input  logic [T_DATA_RATIO-1:0]              mask_i,
   input  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] data_i,
   output logic [T_DATA_WIDTH-1:0]              lane_data_o,
   output logic [IDX_W-1:0]                     lane_idx_o,
   output logic                                 final_o
);

   mask_ext_t   mask_ext;
   int unsigned idx;

   always_comb begin
      mask_ext    = mask_ext_t'(mask_i);
      idx         = lowest_set_idx(mask_ext);
      lane_idx_o  = IDX_W'(idx);
      lane_data_o = data_i[idx*T_DATA_WIDTH +: T_DATA_WIDTH];
      final_o     = is_onehot(mask_ext);
   end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: buffers one wide word and emits its kept
// lanes lowest first, refilling on the final beat so words stream without gaps.
module stream_downsize
   import stream_pkg::*;
#(
   parameter int T_DATA_WIDTH = T_DATA_WIDTH_DEF,
   parameter int T_DATA_RATIO = T_DATA_RATIO_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] s_data_i,
   input  logic [T_DATA_RATIO-1:0]              s_keep_i,
   input  logic                                 s_last_i,
   input  logic                                 s_valid_i,
   output logic                                 s_ready_o,
   output logic [T_DATA_WIDTH-1:0]              m_data_o,
   output logic                                 m_last_o,
   output logic                                 m_valid_o,
   input  logic                                 m_ready_i
);

   localparam int IDX_W = $clog2(T_DATA_RATIO);

   logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] data_q, data_d;
   logic [T_DATA_RATIO-1:0]              mask_q, mask_d;
   logic                                 last_q, last_d;
   logic                                 full_q, full_d;
   logic [T_DATA_WIDTH-1:0]              hold_q, hold_d;

   logic [T_DATA_WIDTH-1:0] lane_data;
   logic [IDX_W-1:0]        lane_idx;
   logic                    lane_final;
   logic                    m_valid;
   logic                    beat_hs;
   logic                    s_ready;
   logic                    word_acc;

   stream_lane_sel #(
      .T_DATA_WIDTH (T_DATA_WIDTH),
      .T_DATA_RATIO (T_DATA_RATIO)
   ) u_lane_sel (
      .mask_i      (mask_q),
      .data_i      (data_q),
      .lane_data_o (lane_data),
      .lane_idx_o  (lane_idx),
      .final_o     (lane_final)
   );

   assign m_valid  = full_q && (mask_q != '0);
   assign beat_hs  = m_valid && m_ready_i;
   // Refill is allowed while the last pending lane is leaving, so no bubble.
   assign s_ready  = !full_q || (beat_hs && lane_final);
   assign word_acc = s_valid_i && s_ready;

   always_comb begin
      data_d = data_q;
      mask_d = mask_q;
      last_d = last_q;
      hold_d = hold_q;
      if (m_valid) hold_d = lane_data;
      if (beat_hs) mask_d = mask_q & ~(T_DATA_RATIO'(1) << lane_idx);
      if (word_acc) begin
         data_d = s_data_i;
         mask_d = s_keep_i;
         last_d = s_last_i;
      end
      // An all-zero keep word leaves nothing to emit, so the buffer stays empty.
      full_d = (mask_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
         last_q <= 1'b0;
         full_q <= 1'b0;
         hold_q <= '0;
      end else begin
         mask_q <= mask_d;
         last_q <= last_d;
         full_q <= full_d;
         hold_q <= hold_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   // Idle output repeats the last beat driven rather than following the buffer.
   assign m_data_o  = m_valid ? lane_data : hold_q;
   assign m_last_o  = m_valid && lane_final && last_q;
   assign m_valid_o = m_valid;
   assign s_ready_o = s_ready;

   a_zero_keep_last : assert property (@(posedge clk) disable iff (!rst_n)
      !(word_acc && (s_keep_i == '0) && s_last_i));

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize: directed scenarios plus a random
// packed-word stream compared against the original narrow beat sequence.
module tb_stream_downsize;

   localparam int W = 4;
   localparam int R = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [W*R-1:0]   s_data_i = '0;
   logic [R-1:0]     s_keep_i = '0;
   logic             s_last_i = 1'b0;
   logic             s_valid_i = 1'b0;
   logic             s_ready_o;
   logic [W-1:0]     m_data_o;
   logic             m_last_o;
   logic             m_valid_o;
   logic             m_ready_i = 1'b0;

   int checks = 0;
   int failures = 0;
   bit done = 1'b0;

   always #5 clk = ~clk;

   stream_downsize #(
      .T_DATA_WIDTH (W),
      .T_DATA_RATIO (R)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data_i  (s_data_i),
      .s_keep_i  (s_keep_i),
      .s_last_i  (s_last_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .m_data_o  (m_data_o),
      .m_last_o  (m_last_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i)
   );

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic drive_word(input logic [W*R-1:0] d, input logic [R-1:0] k, input logic l);
      s_valid_i = 1'b1;
      s_data_i  = d;
      s_keep_i  = k;
      s_last_i  = l;
   endtask

   // {m_valid, m_last, m_data, s_ready}
   function automatic logic [W+2:0] obs();
      return {m_valid_o, m_last_o, m_data_o, s_ready_o};
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (obs() !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
         failures++;
         $display("FAIL reset_asserted got=%b exp=%b", obs(), {1'b0, 1'b0, 4'h0, 1'b1});
      end
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (obs() !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, obs(), {1'b0, 1'b0, 4'h0, 1'b1});
         end
      end
   endtask

   task automatic test_basic;
      m_ready_i = 1'b1;
      drive_word(8'hA5, 2'b11, 1'b1);
      settle();
      checks++;
      if (s_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL basic_accept_ready got=%b exp=1", s_ready_o);
      end
      tick();
      s_valid_i = 1'b0;
      settle();
      checks++;
      if (obs() !== {1'b1, 1'b0, 4'h5, 1'b0}) begin
         failures++;
         $display("FAIL basic_beat0 got=%b exp=%b", obs(), {1'b1, 1'b0, 4'h5, 1'b0});
      end
      tick();
      checks++;
      if (obs() !== {1'b1, 1'b1, 4'hA, 1'b1}) begin
         failures++;
         $display("FAIL basic_beat1 got=%b exp=%b", obs(), {1'b1, 1'b1, 4'hA, 1'b1});
      end
      tick();
      checks++;
      if (obs() !== {1'b0, 1'b0, 4'hA, 1'b1}) begin
         failures++;
         $display("FAIL basic_drained got=%b exp=%b", obs(), {1'b0, 1'b0, 4'hA, 1'b1});
      end
   endtask

   task automatic test_back_to_back;
      logic [W*R-1:0] words [3];
      int wi;
      words[0] = 8'h21;
      words[1] = 8'h43;
      words[2] = 8'h65;
      wi = 0;
      m_ready_i = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) tick();
         if (wi < 3) drive_word(words[wi], 2'b11, wi == 2);
         else s_valid_i = 1'b0;
         settle();
         if (c > 0) begin
            checks++;
            if ({m_valid_o, m_last_o, m_data_o} !== {1'b1, c == 6, W'(c)}) begin
               failures++;
               $display("FAIL b2b_beat cyc=%0d got=%b exp=%b", c, {m_valid_o, m_last_o, m_data_o},
                        {1'b1, c == 6, W'(c)});
            end
         end
         if (s_valid_i && s_ready_o) wi++;
      end
      checks++;
      if (wi != 3) begin
         failures++;
         $display("FAIL b2b_words_accepted got=%0d exp=3", wi);
      end
      tick();
      checks++;
      if (m_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drained got=%b exp=0", m_valid_o);
      end
   endtask

   task automatic test_single_lane;
      m_ready_i = 1'b1;
      drive_word(8'hC3, 2'b01, 1'b1);
      tick();
      drive_word(8'hB7, 2'b11, 1'b0);
      settle();
      checks++;
      if (obs() !== {1'b1, 1'b1, 4'h3, 1'b1}) begin
         failures++;
         $display("FAIL single_lane_beat got=%b exp=%b", obs(), {1'b1, 1'b1, 4'h3, 1'b1});
      end
      tick();
      s_valid_i = 1'b0;
      settle();
      checks++;
      if (obs() !== {1'b1, 1'b0, 4'h7, 1'b0}) begin
         failures++;
         $display("FAIL single_next_beat0 got=%b exp=%b", obs(), {1'b1, 1'b0, 4'h7, 1'b0});
      end
      tick();
      checks++;
      if (obs() !== {1'b1, 1'b0, 4'hB, 1'b1}) begin
         failures++;
         $display("FAIL single_next_beat1 got=%b exp=%b", obs(), {1'b1, 1'b0, 4'hB, 1'b1});
      end
      tick();
      checks++;
      if (obs() !== {1'b0, 1'b0, 4'hB, 1'b1}) begin
         failures++;
         $display("FAIL single_drained got=%b exp=%b", obs(), {1'b0, 1'b0, 4'hB, 1'b1});
      end
   endtask

   task automatic test_sparse_keep;
      m_ready_i = 1'b1;
      drive_word(8'hD4, 2'b10, 1'b0);
      tick();
      drive_word(8'h5A, 2'b00, 1'b0);
      settle();
      checks++;
      if (obs() !== {1'b1, 1'b0, 4'hD, 1'b1}) begin
         failures++;
         $display("FAIL sparse_upper_lane got=%b exp=%b", obs(), {1'b1, 1'b0, 4'hD, 1'b1});
      end
      tick();
      s_valid_i = 1'b0;
      settle();
      checks++;
      if (obs() !== {1'b0, 1'b0, 4'hD, 1'b1}) begin
         failures++;
         $display("FAIL zero_keep_discard got=%b exp=%b", obs(), {1'b0, 1'b0, 4'hD, 1'b1});
      end
      drive_word(8'hE1, 2'b10, 1'b1);
      tick();
      s_valid_i = 1'b0;
      settle();
      checks++;
      if (obs() !== {1'b1, 1'b1, 4'hE, 1'b1}) begin
         failures++;
         $display("FAIL sparse_last got=%b exp=%b", obs(), {1'b1, 1'b1, 4'hE, 1'b1});
      end
      tick();
      checks++;
      if (obs() !== {1'b0, 1'b0, 4'hE, 1'b1}) begin
         failures++;
         $display("FAIL sparse_drained got=%b exp=%b", obs(), {1'b0, 1'b0, 4'hE, 1'b1});
      end
   endtask

   task automatic test_backpressure;
      logic [2:0] rdy_seq [4];
      logic [W+2:0] exp_seq [4];
      rdy_seq = '{3'd0, 3'd0, 3'd1, 3'd1};
      exp_seq = '{{1'b1, 1'b0, 4'h6, 1'b0}, {1'b1, 1'b0, 4'h6, 1'b0},
                  {1'b1, 1'b0, 4'h6, 1'b0}, {1'b1, 1'b1, 4'h9, 1'b1}};
      m_ready_i = 1'b1;
      drive_word(8'h96, 2'b11, 1'b1);
      for (int c = 0; c < 4; c++) begin
         tick();
         s_valid_i = 1'b0;
         m_ready_i = rdy_seq[c][0];
         settle();
         checks++;
         if (obs() !== exp_seq[c]) begin
            failures++;
            $display("FAIL backpressure cyc=%0d got=%b exp=%b", c, obs(), exp_seq[c]);
         end
      end
      tick();
      checks++;
      if (obs() !== {1'b0, 1'b0, 4'h9, 1'b1}) begin
         failures++;
         $display("FAIL backpressure_drained got=%b exp=%b", obs(), {1'b0, 1'b0, 4'h9, 1'b1});
      end
   endtask

   task automatic test_reset_mid_packet;
      m_ready_i = 1'b0;
      drive_word(8'h78, 2'b11, 1'b1);
      tick();
      s_valid_i = 1'b0;
      settle();
      checks++;
      if (obs() !== {1'b1, 1'b0, 4'h8, 1'b0}) begin
         failures++;
         $display("FAIL midpkt_stalled got=%b exp=%b", obs(), {1'b1, 1'b0, 4'h8, 1'b0});
      end
      rst_n = 1'b0;
      settle();
      checks++;
      if (obs() !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
         failures++;
         $display("FAIL midpkt_async_flush got=%b exp=%b", obs(), {1'b0, 1'b0, 4'h0, 1'b1});
      end
      tick();
      rst_n = 1'b1;
      m_ready_i = 1'b1;
      tick();
      checks++;
      if (obs() !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
         failures++;
         $display("FAIL midpkt_after_reset got=%b exp=%b", obs(), {1'b0, 1'b0, 4'h0, 1'b1});
      end
   endtask

   task automatic test_random;
      logic [W-1:0]   beat_q [$];
      logic           last_q [$];
      logic [W*R-1:0] wd_q [$];
      logic [R-1:0]   wk_q [$];
      logic           wl_q [$];
      logic [W-1:0]   rx_d [$];
      logic           rx_l [$];
      logic [W*R-1:0] wd;
      logic [R-1:0]   keep;
      logic           wl;
      bit             stop;
      int             len;
      int             pos;
      int             n;

      n = 0;
      while (n < 1000) begin
         len = $urandom_range(1, 7);
         for (int i = 0; i < len; i++) begin
            beat_q.push_back(W'($urandom));
            last_q.push_back(i == len - 1);
            n++;
         end
      end

      // Pack the narrow stream into wide words with random non-empty keep
      // masks; a packet end always closes its word.
      pos = 0;
      while (pos < beat_q.size()) begin
         if ($urandom_range(9) == 0) begin
            wd_q.push_back((W*R)'($urandom));
            wk_q.push_back('0);
            wl_q.push_back(1'b0);
         end
         keep = R'($urandom_range(1, (1 << R) - 1));
         wd   = (W*R)'($urandom);
         wl   = 1'b0;
         stop = 1'b0;
         for (int l = 0; l < R; l++) begin
            if (stop) keep[l] = 1'b0;
            else if (keep[l]) begin
               wd[l*W +: W] = beat_q[pos];
               wl = last_q[pos];
               pos++;
               if (wl || pos == beat_q.size()) stop = 1'b1;
            end
         end
         wd_q.push_back(wd);
         wk_q.push_back(keep);
         wl_q.push_back(wl);
      end

      done = 1'b0;
      fork
         begin : driver
            int t;
            for (int w = 0; w < wd_q.size(); w++) begin
               while ($urandom_range(3) == 0) begin
                  s_valid_i = 1'b0;
                  tick();
               end
               drive_word(wd_q[w], wk_q[w], wl_q[w]);
               t = 0;
               while (1) begin
                  @(negedge clk);
                  if (s_ready_o) break;
                  t++;
                  if (t > 2000) break;
               end
               if (t > 2000) begin
                  checks++;
                  failures++;
                  $display("FAIL random_accept_timeout word=%0d", w);
                  break;
               end
               tick();
            end
            s_valid_i = 1'b0;
         end
         begin : ready_gen
            while (!done) begin
               tick();
               m_ready_i = ($urandom_range(3) != 0);
            end
            m_ready_i = 1'b1;
         end
         begin : collector
            int cyc;
            logic pv, pr, pl;
            logic [W-1:0] pd;
            cyc = 0;
            pv = 1'b0;
            pr = 1'b0;
            pl = 1'b0;
            pd = '0;
            while (rx_d.size() < beat_q.size() && cyc < 20000) begin
               @(negedge clk);
               cyc++;
               if (pv && !pr) begin
                  checks++;
                  if ({m_valid_o, m_last_o, m_data_o} !== {1'b1, pl, pd}) begin
                     failures++;
                     $display("FAIL random_stall_hold cyc=%0d got=%b exp=%b", cyc,
                              {m_valid_o, m_last_o, m_data_o}, {1'b1, pl, pd});
                  end
               end
               if (m_valid_o && m_ready_i) begin
                  rx_d.push_back(m_data_o);
                  rx_l.push_back(m_last_o);
               end
               pv = m_valid_o;
               pr = m_ready_i;
               pd = m_data_o;
               pl = m_last_o;
            end
            done = 1'b1;
         end
      join

      checks++;
      if (rx_d.size() != beat_q.size()) begin
         failures++;
         $display("FAIL random_beat_count got=%0d exp=%0d", rx_d.size(), beat_q.size());
      end
      for (int i = 0; i < beat_q.size() && i < rx_d.size(); i++) begin
         checks++;
         if ({rx_l[i], rx_d[i]} !== {last_q[i], beat_q[i]}) begin
            failures++;
            $display("FAIL random_beat idx=%0d got=%b/%h exp=%b/%h", i, rx_l[i], rx_d[i],
                     last_q[i], beat_q[i]);
         end
      end
      tick();
      checks++;
      if (m_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL random_drained got=%b exp=0", m_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_single_lane();
      test_sparse_keep();
      test_backpressure();
      test_reset_mid_packet();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
